// File: rtl/commit_trace_packer_if.sv
// Commit-trace bus between retire stage, packer and commit monitor.
// The packer owns the slave side; the retire/monitor harness is master.
interface commit_trace_packer_if #(
  parameter int XLEN      = 64,
  parameter int INST_BITS = 32
);
  logic                 retire_valid;
  logic                 retire_ready;
  logic [XLEN-1:0]      retire_pc;
  logic [INST_BITS-1:0] retire_inst;
  logic [XLEN-1:0]      retire_wdata;
  logic [XLEN-1:0]      retire_mstatus;
  logic                 retire_check;
  logic                 retire_pending;
  logic [4:0]           retire_rd;
  logic                 ll_wb_valid;
  logic [4:0]           ll_wb_rd;
  logic [XLEN-1:0]      ll_wb_data;
  logic                 trap_valid;
  logic [XLEN-1:0]      trap_cause;
  logic                 out_valid;
  logic [XLEN-1:0]      out_pc;
  logic [INST_BITS-1:0] out_inst;
  logic [XLEN-1:0]      out_wdata;
  logic [XLEN-1:0]      out_mstatus;
  logic                 out_check;
  logic                 out_int_xcpt;
  logic [XLEN-1:0]      out_cause;
  logic                 err_overflow;
  logic                 err_orphan_wb;

  modport master (
    output retire_valid, retire_pc, retire_inst,
    output retire_wdata, retire_mstatus,
    output retire_check, retire_pending, retire_rd,
    output ll_wb_valid, ll_wb_rd, ll_wb_data,
    output trap_valid, trap_cause,
    input  retire_ready,
    input  out_valid, out_pc, out_inst,
    input  out_wdata, out_mstatus, out_check,
    input  out_int_xcpt, out_cause,
    input  err_overflow, err_orphan_wb
  );

  modport slave (
    input  retire_valid, retire_pc, retire_inst,
    input  retire_wdata, retire_mstatus,
    input  retire_check, retire_pending, retire_rd,
    input  ll_wb_valid, ll_wb_rd, ll_wb_data,
    input  trap_valid, trap_cause,
    output retire_ready,
    output out_valid, out_pc, out_inst,
    output out_wdata, out_mstatus, out_check,
    output out_int_xcpt, out_cause,
    output err_overflow, err_orphan_wb
  );
endinterface

// File: rtl/commit_trace_packer.sv
// In-order commit buffer: holds retires until late data resolves,
// emits one commit per cycle and defers traps behind older commits.
module commit_trace_packer #(
  parameter int XLEN      = 64,
  parameter int INST_BITS = 32,
  parameter int DEPTH     = 8
) (
  input  logic clock,
  input  logic reset,
  commit_trace_packer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [INST_BITS-1:0] inst;
    logic [XLEN-1:0]      wdata;
    logic [XLEN-1:0]      mstatus;
    logic                 check;
    logic                 pending;
    logic [4:0]           rd;
  } entry_t;

  typedef enum logic {
    TRAP_IDLE,
    TRAP_ARMED
  } trap_state_t;

  entry_t               ent_q [DEPTH];
  logic [PW-1:0]        head_q;
  logic [PW-1:0]        tail_q;
  logic [PW:0]          count_q;
  logic [PW:0]          count_d;
  logic                 ready;
  logic                 enq;
  logic                 deq;
  logic                 wb_hit;
  logic [PW-1:0]        wb_idx;
  trap_state_t          trap_q;
  trap_state_t          trap_d;
  logic                 trap_emit;
  logic [XLEN-1:0]      cause_q;
  logic                 out_valid_q;
  logic [XLEN-1:0]      out_pc_q;
  logic [INST_BITS-1:0] out_inst_q;
  logic [XLEN-1:0]      out_wdata_q;
  logic [XLEN-1:0]      out_mstatus_q;
  logic                 out_check_q;
  logic                 out_xcpt_q;
  logic [XLEN-1:0]      out_cause_q;
  logic                 err_ovf_q;
  logic                 err_orph_q;

  assign ready   = count_q < DEPTH_C;
  assign enq     = bus.retire_valid && ready;
  assign deq     = (count_q != '0) && !ent_q[head_q].pending;
  assign count_d = count_q + (PW+1)'(enq) - (PW+1)'(deq);

  // Oldest resident pending entry waiting on the writeback register.
  always_comb begin
    wb_hit = 1'b0;
    wb_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!wb_hit && ((PW+1)'(i) < count_q) &&
          ent_q[head_q + PW'(i)].pending &&
          (ent_q[head_q + PW'(i)].rd == bus.ll_wb_rd)) begin
        wb_hit = 1'b1;
        wb_idx = head_q + PW'(i);
      end
    end
  end

  // Trap waits armed until the buffer has fully drained.
  always_comb begin
    trap_d    = trap_q;
    trap_emit = 1'b0;
    unique case (trap_q)
      TRAP_IDLE: begin
        if (bus.trap_valid) trap_d = TRAP_ARMED;
      end
      TRAP_ARMED: begin
        if ((count_q == '0) && !deq) begin
          trap_emit = 1'b1;
          if (!bus.trap_valid) trap_d = TRAP_IDLE;
        end
      end
      default: trap_d = TRAP_IDLE;
    endcase
  end

  // Pointers, trap state, output registers and sticky error flags.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      trap_q        <= TRAP_IDLE;
      cause_q       <= '0;
      out_valid_q   <= 1'b0;
      out_pc_q      <= '0;
      out_inst_q    <= '0;
      out_wdata_q   <= '0;
      out_mstatus_q <= '0;
      out_check_q   <= 1'b0;
      out_xcpt_q    <= 1'b0;
      out_cause_q   <= '0;
      err_ovf_q     <= 1'b0;
      err_orph_q    <= 1'b0;
    end else begin
      count_q     <= count_d;
      trap_q      <= trap_d;
      out_valid_q <= deq;
      out_xcpt_q  <= trap_emit;
      if (enq) tail_q <= tail_q + 1'b1;
      if (deq) begin
        head_q        <= head_q + 1'b1;
        out_pc_q      <= ent_q[head_q].pc;
        out_inst_q    <= ent_q[head_q].inst;
        out_wdata_q   <= ent_q[head_q].wdata;
        out_mstatus_q <= ent_q[head_q].mstatus;
        out_check_q   <= ent_q[head_q].check;
      end
      if (trap_emit) out_cause_q <= cause_q;
      if (bus.trap_valid) cause_q <= bus.trap_cause;
      if (bus.retire_valid && !ready) err_ovf_q <= 1'b1;
      if (bus.ll_wb_valid && !wb_hit) err_orph_q <= 1'b1;
    end
  end

  // Entry storage: enqueue at tail, late data resolves in place.
  always_ff @(posedge clock) begin
    if (enq) begin
      ent_q[tail_q].pc      <= bus.retire_pc;
      ent_q[tail_q].inst    <= bus.retire_inst;
      ent_q[tail_q].wdata   <= bus.retire_pending ? '0
                                                  : bus.retire_wdata;
      ent_q[tail_q].mstatus <= bus.retire_mstatus;
      ent_q[tail_q].check   <= bus.retire_check;
      ent_q[tail_q].pending <= bus.retire_pending;
      ent_q[tail_q].rd      <= bus.retire_rd;
    end
    if (bus.ll_wb_valid && wb_hit) begin
      ent_q[wb_idx].wdata   <= bus.ll_wb_data;
      ent_q[wb_idx].pending <= 1'b0;
    end
  end

  assign bus.retire_ready  = ready;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_pc        = out_pc_q;
  assign bus.out_inst      = out_inst_q;
  assign bus.out_wdata     = out_wdata_q;
  assign bus.out_mstatus   = out_mstatus_q;
  assign bus.out_check     = out_check_q;
  assign bus.out_int_xcpt  = out_xcpt_q;
  assign bus.out_cause     = out_cause_q;
  assign bus.err_overflow  = err_ovf_q;
  assign bus.err_orphan_wb = err_orph_q;
endmodule

// File: tb/tb_commit_trace_packer.sv
// Directed bench for commit_trace_packer: logs every emitted
// commit/trap and compares against hand-computed expectations.
module tb_commit_trace_packer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  commit_trace_packer_if #(.XLEN(64), .INST_BITS(32)) bus ();

  commit_trace_packer #(
    .XLEN(64), .INST_BITS(32), .DEPTH(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    int          cyc;
    bit          trap;
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] wdata;
    logic [63:0] mst;
    logic        chk;
    logic [63:0] cause;
  } rec_t;

  rec_t log_q[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int e0, w, f0, t0;

  // Cycle counter: value after edge N is N.
  always @(posedge clock) cyc <= cyc + 1;

  // Record every emitted commit and trap mid-cycle.
  always @(negedge clock) begin
    rec_t r;
    r.cyc = cyc;
    r.pc = bus.out_pc;
    r.inst = bus.out_inst;
    r.wdata = bus.out_wdata;
    r.mst = bus.out_mstatus;
    r.chk = bus.out_check;
    r.cause = bus.out_cause;
    if (bus.out_valid) begin
      r.trap = 1'b0;
      log_q.push_back(r);
    end
    if (bus.out_int_xcpt) begin
      r.trap = 1'b1;
      log_q.push_back(r);
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic idle_in();
    bus.retire_valid = 1'b0;
    bus.ll_wb_valid  = 1'b0;
    bus.trap_valid   = 1'b0;
  endtask

  task automatic put(input logic [63:0] pc,
                     input logic [31:0] inst,
                     input logic [63:0] wd,
                     input logic pend,
                     input logic [4:0] rd);
    bus.retire_valid   = 1'b1;
    bus.retire_pc      = pc;
    bus.retire_inst    = inst;
    bus.retire_wdata   = wd;
    bus.retire_mstatus = {pc[31:0], inst};
    bus.retire_check   = pc[2];
    bus.retire_pending = pend;
    bus.retire_rd      = rd;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [63:0] d);
    bus.ll_wb_valid = 1'b1;
    bus.ll_wb_rd    = rd;
    bus.ll_wb_data  = d;
  endtask

  task automatic exp_commit(input int k, input string tag,
                            input logic [63:0] pc,
                            input logic [63:0] wd,
                            input int c);
    if (log_q.size() > k) begin
      check({tag, ".kind"}, 64'(log_q[k].trap), 64'd0);
      check({tag, ".pc"}, log_q[k].pc, pc);
      check({tag, ".wdata"}, log_q[k].wdata, wd);
      check({tag, ".cyc"}, 64'(log_q[k].cyc), 64'(c));
    end else begin
      check({tag, ".missing"}, 64'(log_q.size()), 64'(k + 1));
    end
  endtask

  initial begin
    idle_in();
    bus.retire_pc = '0;
    bus.retire_inst = '0;
    bus.retire_wdata = '0;
    bus.retire_mstatus = '0;
    bus.retire_check = 1'b0;
    bus.retire_pending = 1'b0;
    bus.retire_rd = '0;
    bus.ll_wb_rd = '0;
    bus.ll_wb_data = '0;
    bus.trap_cause = '0;

    // reset state
    reset = 1'b0;
    ticks(3);
    reset = 1'b1;
    tick();
    check("rst.ready", 64'(bus.retire_ready), 64'd1);
    check("rst.valid", 64'(bus.out_valid), 64'd0);
    check("rst.xcpt", 64'(bus.out_int_xcpt), 64'd0);
    check("rst.pc", bus.out_pc, 64'd0);
    check("rst.cause", bus.out_cause, 64'd0);
    check("rst.ovf", 64'(bus.err_overflow), 64'd0);
    check("rst.orph", 64'(bus.err_orphan_wb), 64'd0);

    // three back-to-back resolved retires
    log_q.delete();
    put(64'h8000_0000, 32'h0000_0013, 64'h11, 1'b0, 5'd0);
    tick();
    e0 = cyc;
    put(64'h8000_0004, 32'h0010_0093, 64'h22, 1'b0, 5'd0);
    tick();
    put(64'h8000_0008, 32'h0020_0113, 64'h33, 1'b0, 5'd0);
    tick();
    idle_in();
    ticks(6);
    check("t1.n", 64'(log_q.size()), 64'd3);
    exp_commit(0, "t1.a", 64'h8000_0000, 64'h11, e0 + 1);
    exp_commit(1, "t1.b", 64'h8000_0004, 64'h22, e0 + 2);
    exp_commit(2, "t1.c", 64'h8000_0008, 64'h33, e0 + 3);
    if (log_q.size() == 3) begin
      check("t1.a.inst", 64'(log_q[0].inst), 64'h13);
      check("t1.a.mst", log_q[0].mst, 64'h8000_0000_0000_0013);
      check("t1.a.chk", 64'(log_q[0].chk), 64'd0);
      check("t1.b.inst", 64'(log_q[1].inst), 64'h0010_0093);
      check("t1.b.mst", log_q[1].mst, 64'h8000_0004_0010_0093);
      check("t1.b.chk", 64'(log_q[1].chk), 64'd1);
      check("t1.c.inst", 64'(log_q[2].inst), 64'h0020_0113);
    end

    // pending head blocks a resolved younger entry
    log_q.delete();
    put(64'h100, 32'h0000_0013, 64'hFFFF, 1'b1, 5'd5);
    tick();
    put(64'h104, 32'h0000_0013, 64'hBB, 1'b0, 5'd0);
    tick();
    idle_in();
    ticks(3);
    check("t2.hold", 64'(log_q.size()), 64'd0);
    wb(5'd5, 64'hDEAD);
    tick();
    w = cyc;
    idle_in();
    ticks(5);
    check("t2.n", 64'(log_q.size()), 64'd2);
    exp_commit(0, "t2.a", 64'h100, 64'hDEAD, w + 1);
    exp_commit(1, "t2.b", 64'h104, 64'hBB, w + 2);

    // same-rd pendings resolve oldest first; orphan writeback
    log_q.delete();
    put(64'h200, 32'h0000_0013, 64'h0, 1'b1, 5'd7);
    tick();
    put(64'h204, 32'h0000_0013, 64'h0, 1'b1, 5'd7);
    tick();
    idle_in();
    tick();
    wb(5'd9, 64'h99);
    tick();
    idle_in();
    tick();
    check("t3.orph", 64'(bus.err_orphan_wb), 64'd1);
    check("t3.hold", 64'(log_q.size()), 64'd0);
    check("t3.ovf", 64'(bus.err_overflow), 64'd0);
    wb(5'd7, 64'd1);
    tick();
    w = cyc;
    wb(5'd7, 64'd2);
    tick();
    idle_in();
    ticks(5);
    check("t3.n", 64'(log_q.size()), 64'd2);
    exp_commit(0, "t3.a", 64'h200, 64'd1, w + 1);
    exp_commit(1, "t3.b", 64'h204, 64'd2, w + 2);

    // fill behind a pending head, overflow, drain, refill
    log_q.delete();
    put(64'h300, 32'h0000_0013, 64'h0, 1'b1, 5'd3);
    tick();
    for (int i = 1; i < 8; i++) begin
      put(64'h300 + 64'(4 * i), 32'h0000_0013, 64'(i), 1'b0, 5'd0);
      tick();
    end
    idle_in();
    check("t4.full", 64'(bus.retire_ready), 64'd0);
    put(64'h3F0, 32'h0000_0013, 64'hF0, 1'b0, 5'd0);
    tick();
    idle_in();
    check("t4.ovf", 64'(bus.err_overflow), 64'd1);
    check("t4.hold", 64'(log_q.size()), 64'd0);
    wb(5'd3, 64'h3333);
    tick();
    w = cyc;
    idle_in();
    ticks(12);
    check("t4.n", 64'(log_q.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      exp_commit(i, $sformatf("t4.d%0d", i), 64'h300 + 64'(4 * i),
                 (i == 0) ? 64'h3333 : 64'(i), w + 1 + i);
    end
    log_q.delete();
    put(64'h400, 32'h0000_0013, 64'h40, 1'b0, 5'd0);
    tick();
    f0 = cyc;
    for (int i = 1; i < 8; i++) begin
      put(64'h400 + 64'(4 * i), 32'h0000_0013, 64'h40 + 64'(i),
          1'b0, 5'd0);
      tick();
    end
    idle_in();
    ticks(12);
    check("t4.r.n", 64'(log_q.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      exp_commit(i, $sformatf("t4.r%0d", i), 64'h400 + 64'(4 * i),
                 64'h40 + 64'(i), f0 + 1 + i);
    end

    // trap deferred behind two buffered commits
    log_q.delete();
    put(64'h500, 32'h0000_0013, 64'h55, 1'b0, 5'd0);
    tick();
    e0 = cyc;
    put(64'h504, 32'h0000_0013, 64'h66, 1'b0, 5'd0);
    bus.trap_valid = 1'b1;
    bus.trap_cause = 64'h8000_0000_0000_0007;
    tick();
    idle_in();
    ticks(6);
    check("t5.n", 64'(log_q.size()), 64'd3);
    exp_commit(0, "t5.a", 64'h500, 64'h55, e0 + 1);
    exp_commit(1, "t5.b", 64'h504, 64'h66, e0 + 2);
    if (log_q.size() == 3) begin
      check("t5.t.kind", 64'(log_q[2].trap), 64'd1);
      check("t5.t.cause", log_q[2].cause, 64'h8000_0000_0000_0007);
      check("t5.t.cyc", 64'(log_q[2].cyc), 64'(e0 + 3));
    end

    // trap with an empty buffer
    log_q.delete();
    bus.trap_valid = 1'b1;
    bus.trap_cause = 64'h5;
    tick();
    t0 = cyc;
    idle_in();
    ticks(4);
    check("t5e.n", 64'(log_q.size()), 64'd1);
    if (log_q.size() == 1) begin
      check("t5e.kind", 64'(log_q[0].trap), 64'd1);
      check("t5e.cause", log_q[0].cause, 64'h5);
      check("t5e.cyc", 64'(log_q[0].cyc), 64'(t0 + 1));
    end

    // reset discards buffered entries and the armed trap
    log_q.delete();
    put(64'h600, 32'h0000_0013, 64'h0, 1'b1, 5'd1);
    tick();
    for (int i = 1; i < 5; i++) begin
      put(64'h600 + 64'(4 * i), 32'h0000_0013, 64'(i), 1'b0, 5'd0);
      if (i == 4) begin
        bus.trap_valid = 1'b1;
        bus.trap_cause = 64'h9;
      end
      tick();
    end
    idle_in();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    ticks(15);
    check("t6.none", 64'(log_q.size()), 64'd0);
    check("t6.ready", 64'(bus.retire_ready), 64'd1);
    check("t6.ovf", 64'(bus.err_overflow), 64'd0);
    check("t6.orph", 64'(bus.err_orphan_wb), 64'd0);
    put(64'h700, 32'h0000_0013, 64'h77, 1'b0, 5'd0);
    tick();
    e0 = cyc;
    idle_in();
    ticks(4);
    check("t6.n", 64'(log_q.size()), 64'd1);
    exp_commit(0, "t6.a", 64'h700, 64'h77, e0 + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/commit_trace_packer.md
# commit_trace_packer

Sits between the core retire stage and the co-simulation commit monitor, on the DUT side of the commit-trace interface. Accepts retire events in program order, including events whose register write data is still outstanding from long-latency units. Holds them in an in-order buffer until their data is resolved, then emits one fully-formed commit per cycle. Defers asynchronous trap notification until every older commit has been emitted, so the monitor sees commits and traps in architectural order.

## Interface

Parameters:
- XLEN, 64, data/PC width
- INST_BITS, 32, instruction width
- DEPTH, 8, buffer entries; power of two, ≥2

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-low
- retire_valid  in  1  retire event this cycle
- retire_ready  out  1  buffer can accept an event
- retire_pc  in  XLEN  retired PC
- retire_inst  in  INST_BITS  retired instruction
- retire_wdata  in  XLEN  write data; ignored when retire_pending=1
- retire_mstatus  in  XLEN  mstatus snapshot
- retire_check  in  1  compare-enable for this commit
- retire_pending  in  1  write data arrives later via ll_wb
- retire_rd  in  5  destination register of a pending event
- ll_wb_valid  in  1  late writeback
- ll_wb_rd  in  5  late writeback register
- ll_wb_data  in  XLEN  late writeback data
- trap_valid  in  1  interrupt/exception request (1-cycle pulse)
- trap_cause  in  XLEN  cause value
- out_valid  out  1  commit emitted (1-cycle pulse)
- out_pc, out_inst, out_wdata, out_mstatus  out  XLEN/INST_BITS/XLEN/XLEN  emitted commit fields
- out_check  out  1  emitted compare-enable
- out_int_xcpt  out  1  trap emitted (1-cycle pulse)
- out_cause  out  XLEN  emitted cause
- err_overflow  out  1  sticky: event offered while full
- err_orphan_wb  out  1  sticky: ll_wb matched no pending entry

## Operation

- Circular buffer: head/tail pointers of log2(DEPTH) bits plus a count of log2(DEPTH)+1 bits. Each entry holds pc, inst, wdata, mstatus, check, pending, rd.
- retire_ready = (count < DEPTH), computed from registered count only. There is no same-cycle dequeue credit.
- Enqueue: when retire_valid && retire_ready, write the event at tail and increment tail (wraps at DEPTH).
- Overflow: retire_valid && !retire_ready drops the event and sets err_overflow. The flag clears only on reset.
- Late writeback: ll_wb_valid searches entries already resident at the start of the cycle. It resolves the oldest entry with pending=1 and rd==ll_wb_rd, writing wdata and clearing pending. No match sets err_orphan_wb. A same-cycle enqueue is never a match candidate.
- Dequeue: when count>0 and the head entry has pending=0, load the output registers, pulse out_valid, and advance head. At most one dequeue per cycle.
- A pending head blocks all younger entries, including resolved ones.
- Trap: trap_valid loads a one-entry trap register (trap_busy, cause).
  - While trap_busy=1, a further trap_valid overwrites the cause (last wins).
  - The trap is emitted as out_int_xcpt=1 with out_cause in a cycle where count==0 and no commit is emitted. trap_busy then clears.
- The monitor never backpressures; every out_valid/out_int_xcpt is consumed in that cycle.

## Timing

- Reset (reset==0 at a clock edge): count, head, tail, trap_busy all 0. out_valid=0, out_int_xcpt=0, out_* data=0, err_*=0. retire_ready=1 in the cycle after reset deasserts.
- Reset mid-operation discards all buffered entries and any pending trap without emitting them.
- Resolved event latency: enqueued at edge E, it is a dequeue candidate in the following cycle, so out_valid is high in the cycle after edge E+1 (2 cycles, empty buffer).
- Pending event: ll_wb at edge W makes the head eligible. out_valid is high in the cycle after edge W+1.
- Enqueue and dequeue in the same cycle leave count unchanged. Full with a dequeue still reports retire_ready=0 in that cycle.
- Trap with an empty buffer: trap_valid at edge T, out_int_xcpt high in the cycle after edge T+1.
- Trap with a non-empty buffer: out_int_xcpt is asserted ≥1 cycle after the last out_valid, never in the same cycle as out_valid.

## Test plan

- Reset, then 3 back-to-back resolved retires (pc 0x80000000/04/08) → out_valid on 3 consecutive cycles starting 2 cycles after the first, fields bit-exact, in order.
- Retire A pending on rd=5, then B resolved, then ll_wb rd=5 data 0xDEAD 4 cycles later → nothing emitted until the writeback. Then A with wdata 0xDEAD, then B on the next cycle.
- Two pending entries, both on rd=7, then two ll_wb rd=7 with data 1 then 2 → oldest gets 1, younger gets 2. ll_wb rd=9 with no pending entry → err_orphan_wb=1 and the buffer is unchanged.
- Fill with DEPTH=8 retires while the head is pending → retire_ready=0. A 9th retire_valid sets err_overflow and is not emitted. Resolve the head → 8 commits drain and pointers wrap correctly across a second fill.
- Two commits buffered, trap_valid cause 0x8000000000000007 in the same cycle as the 2nd enqueue → both commits emitted first, then out_int_xcpt with that cause one cycle after the last commit.
- Assert reset for 1 cycle with 5 entries and a trap buffered → no out_valid/out_int_xcpt afterwards, count=0, err flags 0.
